// File: rtl/pdm_decimator.sv
// PDM microphone front end: bit-clock generator plus a 3rd-order CIC decimator to 16-bit PCM.
// Defining PDM_DC_BLOCK_EN adds a DC-blocking stage after saturation (one extra cycle of latency).
module pdm_decimator #(
  parameter int CLK_DIV = 40,
  parameter int DECIM   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mic_data,
  output logic               mic_clk,
  output logic signed [15:0] sample_out,
  output logic               sample_valid
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DECIM);
  localparam int W     = 2 + 3 * CNT_W;
  localparam int SW    = (W > 17) ? W : 17;
  localparam int SHR   = (W > 17) ? W - 17 : 0;
  localparam int SHL   = (W > 17) ? 0 : 17 - W;

  typedef logic signed [W-1:0]  acc_t;
  typedef logic signed [SW-1:0] scl_t;

  localparam scl_t SAT_MAX = scl_t'(32767);
  localparam scl_t SAT_MIN = scl_t'(-32768);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               mic_clk_q, mic_clk_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  acc_t               int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  acc_t               lat_q, lat_d, lat_prev_q, lat_prev_d;
  acc_t               c1_q, c1_d, c1_prev_q, c1_prev_d;
  acc_t               c2_q, c2_d, c2_prev_q, c2_prev_d;
  logic [2:0]         pipe_q, pipe_d;
  logic [1:0]         settle_q, settle_d;
  logic signed [15:0] sample_q, sample_d;
  logic               valid_q, valid_d;

  logic               capture, emit;
  acc_t               in_bit, c3;
  scl_t               scaled;
  logic signed [15:0] sat;

`ifdef PDM_DC_BLOCK_EN
  logic signed [15:0] dc_x_q, dc_x_d;
  logic               dc_vld_q, dc_vld_d;
  logic signed [17:0] dc_xp_q, dc_xp_d, dc_yp_q, dc_yp_d;
  logic signed [19:0] dc_sum;
`endif

  always_comb begin
    // NOTE: every _d starts as its _q (or 0 for strobes) so no path leaves a signal unassigned and infers a latch.
    div_cnt_d  = div_cnt_q;
    mic_clk_d  = mic_clk_q;
    bit_cnt_d  = bit_cnt_q;
    int1_d     = int1_q;
    int2_d     = int2_q;
    int3_d     = int3_q;
    lat_d      = lat_q;
    lat_prev_d = lat_prev_q;
    c1_d       = c1_q;
    c1_prev_d  = c1_prev_q;
    c2_d       = c2_q;
    c2_prev_d  = c2_prev_q;
    settle_d   = settle_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    emit       = 1'b0;

    capture   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    in_bit    = mic_data ? acc_t'(1) : '1;
    div_cnt_d = capture ? '0 : div_cnt_q + DIV_W'(1);
    mic_clk_d = (div_cnt_d >= DIV_W'(CLK_DIV / 2));
    pipe_d    = {pipe_q[1:0], 1'b0};

    if (capture) begin
      int1_d    = int1_q + in_bit;
      int2_d    = int2_q + int1_d;
      int3_d    = int3_q + int2_d;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (bit_cnt_q == '1) begin
        lat_d     = int3_d;
        pipe_d[0] = 1'b1;
      end
    end

    // Comb chain at the decimated rate: one stage per cycle behind the latched integrator.
    if (pipe_q[0]) begin
      c1_d       = lat_q - lat_prev_q;
      lat_prev_d = lat_q;
    end
    if (pipe_q[1]) begin
      c2_d      = c1_q - c1_prev_q;
      c1_prev_d = c1_q;
    end

    c3     = c2_q - c2_prev_q;
    scaled = (scl_t'(c3) <<< SHL) >>> SHR;
    if (scaled > SAT_MAX)      sat = 16'sh7fff;
    else if (scaled < SAT_MIN) sat = 16'sh8000;
    else                       sat = $signed(scaled[15:0]);

    // The first three decimated samples still carry the filter's start-up transient.
    if (pipe_q[2]) begin
      c2_prev_d = c2_q;
      if (settle_q == 2'd3) emit = 1'b1;
      else                  settle_d = settle_q + 2'd1;
    end

`ifdef PDM_DC_BLOCK_EN
    dc_x_d   = dc_x_q;
    dc_xp_d  = dc_xp_q;
    dc_yp_d  = dc_yp_q;
    dc_vld_d = emit;
    dc_sum   = '0;
    if (emit) dc_x_d = sat;
    if (dc_vld_q) begin
      dc_sum  = 20'(dc_x_q) - 20'(dc_xp_q) + 20'(dc_yp_q) - 20'(dc_yp_q >>> 8);
      dc_xp_d = 18'(dc_x_q);
      if (dc_sum > 20'sd131071)       dc_yp_d = 18'sh1ffff;
      else if (dc_sum < -20'sd131072) dc_yp_d = 18'sh20000;
      else                            dc_yp_d = dc_sum[17:0];
      if (dc_sum > 20'sd32767)        sample_d = 16'sh7fff;
      else if (dc_sum < -20'sd32768)  sample_d = 16'sh8000;
      else                            sample_d = dc_sum[15:0];
      valid_d = 1'b1;
    end
`else
    if (emit) begin
      sample_d = sat;
      valid_d  = 1'b1;
    end
`endif

    // Disabling drops any partial frame and any sample in flight; only the last output is kept.
    if (!enable) begin
      div_cnt_d  = '0;
      mic_clk_d  = 1'b0;
      bit_cnt_d  = '0;
      int1_d     = '0;
      int2_d     = '0;
      int3_d     = '0;
      lat_d      = '0;
      lat_prev_d = '0;
      c1_d       = '0;
      c1_prev_d  = '0;
      c2_d       = '0;
      c2_prev_d  = '0;
      pipe_d     = '0;
      settle_d   = '0;
      sample_d   = sample_q;
      valid_d    = 1'b0;
`ifdef PDM_DC_BLOCK_EN
      dc_x_d     = '0;
      dc_xp_d    = '0;
      dc_yp_d    = '0;
      dc_vld_d   = 1'b0;
`endif
    end
  end

  // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset clears the whole datapath, filter state included, so no pre-reset data reaches the output.
    if (rst) begin
      div_cnt_q  <= '0;
      mic_clk_q  <= 1'b0;
      bit_cnt_q  <= '0;
      int1_q     <= '0;
      int2_q     <= '0;
      int3_q     <= '0;
      lat_q      <= '0;
      lat_prev_q <= '0;
      c1_q       <= '0;
      c1_prev_q  <= '0;
      c2_q       <= '0;
      c2_prev_q  <= '0;
      pipe_q     <= '0;
      settle_q   <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
`ifdef PDM_DC_BLOCK_EN
      dc_x_q     <= '0;
      dc_xp_q    <= '0;
      dc_yp_q    <= '0;
      dc_vld_q   <= 1'b0;
`endif
    end else begin
      div_cnt_q  <= div_cnt_d;
      mic_clk_q  <= mic_clk_d;
      bit_cnt_q  <= bit_cnt_d;
      int1_q     <= int1_d;
      int2_q     <= int2_d;
      int3_q     <= int3_d;
      lat_q      <= lat_d;
      lat_prev_q <= lat_prev_d;
      c1_q       <= c1_d;
      c1_prev_q  <= c1_prev_d;
      c2_q       <= c2_d;
      c2_prev_q  <= c2_prev_d;
      pipe_q     <= pipe_d;
      settle_q   <= settle_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
`ifdef PDM_DC_BLOCK_EN
      dc_x_q     <= dc_x_d;
      dc_xp_q    <= dc_xp_d;
      dc_yp_q    <= dc_yp_d;
      dc_vld_q   <= dc_vld_d;
`endif
    end
  end

  assign mic_clk      = mic_clk_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
endmodule
